// File: rtl/apb_slave_regbank.sv
// APB3 register bank with byte strobes, read-only registers loadable from hardware.
// Latency 2+WAIT_STATES cycles from the setup cycle; PREADY held low during wait states, PSELx drop aborts.
module apb_slave_regbank #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic                           PSELx,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [STRB_WIDTH-1:0]          PSTRB,
    output logic                           PREADY,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PSLVERR,
    input  logic [NUM_REGS-1:0]            hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    localparam int OFS = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << OFS) - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [NUM_REGS-1:0]     sel;
    logic                    addr_err, ro_hit, xfer_err, done, start;
    logic                    pready_c, pslverr_c;
    logic [DATA_WIDTH-1:0]   prdata_c;

    // Decode works on the address captured at setup, not the live bus.
    always_comb begin
        word_idx = addr_q >> OFS;
        addr_err = ((addr_q & LOW_MASK) != '0) || (word_idx >= ADDR_WIDTH'(NUM_REGS));
        sel      = '0;
        ro_hit   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = !addr_err && (word_idx == ADDR_WIDTH'(i));
            ro_hit = ro_hit | (sel[i] & RO_MASK[i]);
        end
        xfer_err = addr_err || (pwrite_q && ro_hit);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        pwrite_d  = pwrite_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        regs_d    = regs_q;
        pready_c  = 1'b0;
        pslverr_c = 1'b0;
        prdata_c  = '0;
        start     = PSELx && !PENABLE;
        done      = (state_q != IDLE) && (cnt_q == 4'd0) && PSELx && PENABLE;

        for (int i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i] && hw_we[i]) begin
                regs_d[i] = hw_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        case (state_q)
            IDLE: ;
            default: begin
                if (!PSELx) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (done) begin
                    state_d  = IDLE;
                    pready_c = 1'b1;
                    if (xfer_err) begin
                        pslverr_c = 1'b1;
                    end else if (pwrite_q) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            for (int k = 0; k < STRB_WIDTH; k++) begin
                                if (sel[i] && strb_q[k]) begin
                                    regs_d[i][k*8 +: 8] = wdata_q[k*8 +: 8];
                                end
                            end
                        end
                    end else begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (sel[i]) begin
                                prdata_c = regs_q[i];
                            end
                        end
                    end
                end else begin
                    // The countdown already runs in SETUP so zero wait states finish there.
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                    state_d = ACCESS;
                end
            end
        endcase

        if (start && (state_q == IDLE || done)) begin
            state_d  = SETUP;
            cnt_d    = 4'(WAIT_STATES);
            addr_d   = PADDR;
            pwrite_d = PWRITE;
            wdata_d  = PWDATA;
            strb_d   = PSTRB;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            pwrite_q <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            pwrite_q <= pwrite_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            regs_q   <= regs_d;
        end
    end

    assign PREADY  = pready_c;
    assign PSLVERR = pslverr_c;
    assign PRDATA  = prdata_c;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank with 2 wait states and register 15 read-only.
module tb_apb_slave_regbank;

    logic         PCLK;
    logic         PRESET;
    logic [31:0]  PADDR;
    logic         PSELx, PENABLE, PWRITE;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic         PREADY, PSLVERR;
    logic [31:0]  PRDATA;
    logic [15:0]  hw_we;
    logic [511:0] hw_wdata;
    logic [511:0] regs_flat;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_regs [16];

    apb_slave_regbank #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .NUM_REGS(16),
        .WAIT_STATES(2), .RO_MASK(16'h8000)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSELx(PSELx),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .hw_we(hw_we), .hw_wdata(hw_wdata), .regs_flat(regs_flat)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_reg%0d", tag, i), 64'(regs_flat[i*32 +: 32]), 64'(exp_regs[i]));
        end
    endtask

    // One APB transfer; ld pulses hw_we[15] with 0xBEEF during cycle 4 of the transfer.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic ld,
                        output logic [31:0] rd, output logic er, output int rc);
        int   cyc;
        logic got;
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cyc = 2; got = 1'b0; rd = '0; er = 1'b0; rc = 0;
        while (!got && cyc < 20) begin
            @(negedge PCLK);
            if (PREADY) begin
                got = 1'b1; rd = PRDATA; er = PSLVERR; rc = cyc;
            end else begin
                @(posedge PCLK); #1;
                cyc++;
                if (ld && cyc == 4) begin
                    hw_we = 16'h8000;
                    hw_wdata[15*32 +: 32] = 32'h0000BEEF;
                end
            end
        end
        if (!got) check("xfer_timeout", 64'd0, 64'd1);
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; hw_we = '0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          rc;

    initial begin
        PRESET = 1'b1; PADDR = '0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PWDATA = '0; PSTRB = '0; hw_we = '0; hw_wdata = '0;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_pready", 64'(PREADY), 64'd0);
        check("rst_pslverr", 64'(PSLVERR), 64'd0);
        check("rst_prdata", 64'(PRDATA), 64'd0);
        check_regs("rst");
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Full-word write then read back, completing in the 4th cycle
        xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, rc);
        check("wr04_cycle", 64'(rc), 64'd4);
        check("wr04_err", 64'(er), 64'd0);
        check("wr04_prdata", 64'(rd), 64'd0);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 1'b0, rd, er, rc);
        check("rd04_cycle", 64'(rc), 64'd4);
        check("rd04_err", 64'(er), 64'd0);
        check("rd04_data", 64'(rd), 64'hDEADBEEF);
        exp_regs[1] = 32'hDEADBEEF;

        // Byte strobes
        xfer(1'b1, 32'h08, 32'h11223344, 4'hF, 1'b0, rd, er, rc);
        xfer(1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 1'b0, rd, er, rc);
        check("wr08_strb_err", 64'(er), 64'd0);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, er, rc);
        check("rd08_data", 64'(rd), 64'h11BB33DD);
        exp_regs[2] = 32'h11BB33DD;
        xfer(1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 1'b0, rd, er, rc);
        check("wr08_nostrb_err", 64'(er), 64'd0);

        // Read-only register: bus write rejected, hardware load accepted
        xfer(1'b1, 32'h3C, 32'h12345678, 4'hF, 1'b0, rd, er, rc);
        check("wr3c_err", 64'(er), 64'd1);
        check("wr3c_cycle", 64'(rc), 64'd4);
        @(negedge PCLK);
        check("post_err_pslverr", 64'(PSLVERR), 64'd0);
        check_regs("ro_wr");
        @(posedge PCLK); #1;
        hw_we = 16'h8004;
        hw_wdata[15*32 +: 32] = 32'h0000CAFE;
        hw_wdata[2*32 +: 32]  = 32'h55555555;
        @(posedge PCLK); #1;
        hw_we = '0;
        exp_regs[15] = 32'h0000CAFE;
        xfer(1'b0, 32'h3C, 32'h0, 4'h0, 1'b0, rd, er, rc);
        check("rd3c_data", 64'(rd), 64'h0000CAFE);
        check("rd3c_err", 64'(er), 64'd0);
        check_regs("hw_ld");

        // Read racing a hardware load sees the old value
        xfer(1'b0, 32'h3C, 32'h0, 4'h0, 1'b1, rd, er, rc);
        check("race_rd_data", 64'(rd), 64'h0000CAFE);
        exp_regs[15] = 32'h0000BEEF;
        check_regs("race");

        // Out-of-range and misaligned reads
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, er, rc);
        check("rd40_err", 64'(er), 64'd1);
        check("rd40_data", 64'(rd), 64'd0);
        xfer(1'b0, 32'h05, 32'h0, 4'h0, 1'b0, rd, er, rc);
        check("rd05_err", 64'(er), 64'd1);
        check("rd05_data", 64'(rd), 64'd0);
        xfer(1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, 1'b0, rd, er, rc);
        check("wr06_err", 64'(er), 64'd1);
        check_regs("bad_addr");

        // PSELx dropped in the 2nd ACCESS cycle aborts the write
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C;
        PWDATA = 32'h12345678; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("abort_c3_ready", 64'(PREADY), 64'd0);
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check("abort_c4_ready", 64'(PREADY), 64'd0);
        check("abort_c4_err", 64'(PSLVERR), 64'd0);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("abort_c5_ready", 64'(PREADY), 64'd0);
        check_regs("abort");
        xfer(1'b1, 32'h0C, 32'h0000A5A5, 4'hF, 1'b0, rd, er, rc);
        check("after_abort_cycle", 64'(rc), 64'd4);
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, rd, er, rc);
        check("after_abort_data", 64'(rd), 64'h0000A5A5);
        exp_regs[3] = 32'h0000A5A5;

        // Reset during ACCESS clears everything immediately
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10;
        PWDATA = 32'h99999999; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        check("arst_pready", 64'(PREADY), 64'd0);
        check("arst_pslverr", 64'(PSLVERR), 64'd0);
        check("arst_prdata", 64'(PRDATA), 64'd0);
        check_regs("arst");
        PSELx = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        check_regs("arst_rel");
        xfer(1'b1, 32'h10, 32'h00000077, 4'hF, 1'b0, rd, er, rc);
        check("post_rst_cycle", 64'(rc), 64'd4);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, rc);
        check("post_rst_data", 64'(rd), 64'h00000077);
        check("post_rst_err", 64'(er), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, APB address width SHALL be configurable.
REQ-002 Parameter DATA_WIDTH, default 32, data width SHALL be configurable (8, 16, 32 or 64).
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, SHALL set the byte-strobe count.
REQ-004 Parameter NUM_REGS, default 16, SHALL set register count (2..256).
REQ-005 Parameter WAIT_STATES, default 0, SHALL set inserted wait cycles per transfer (0..15).
REQ-006 Parameter RO_MASK, default 0, width NUM_REGS, SHALL mark register i read-only when bit i=1.
REQ-007 PCLK  input  1  sole clock; all logic on rising edge.
REQ-008 PRESET  input  1  reset, asynchronous, active-high.
REQ-009 PADDR  input  ADDR_WIDTH  byte address.
REQ-010 PSELx, PENABLE, PWRITE  input  1 each  APB select, enable, direction.
REQ-011 PWDATA  input  DATA_WIDTH  write data; PSTRB  input  STRB_WIDTH  byte strobes.
REQ-012 PREADY  output  1; PRDATA  output  DATA_WIDTH; PSLVERR  output  1.
REQ-013 hw_we  input  NUM_REGS  per-register hardware load enable (effective only on read-only registers).
REQ-014 hw_wdata  input  NUM_REGS*DATA_WIDTH  hardware load data, register i in slice i.
REQ-015 regs_flat  output  NUM_REGS*DATA_WIDTH  current contents of all registers, register i in slice i.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS SHALL be implemented.
REQ-017 IDLE->SETUP when PSELx=1 and PENABLE=0; wait counter loaded with WAIT_STATES; address, direction, data, strobes captured.
REQ-018 SETUP->ACCESS unconditionally on the next edge.
REQ-019 In ACCESS, counter decrements each cycle while nonzero; PREADY=1 combinationally when counter=0 and PSELx=PENABLE=1.
REQ-020 Transfer latency SHALL be 2+WAIT_STATES cycles from setup to the completing edge.
REQ-021 On completion: next state SETUP if PSELx=1 and PENABLE=0 in that cycle (back-to-back), otherwise IDLE.
REQ-022 If PSELx deasserts in SETUP or ACCESS, FSM SHALL return to IDLE with no register update and no PSLVERR.
REQ-023 Word index = PADDR >> log2(STRB_WIDTH); access valid only if low log2(STRB_WIDTH) address bits are zero and index < NUM_REGS.
REQ-024 Valid write to a read/write register SHALL update byte k only where PSTRB[k]=1, at the completing edge; PSTRB=0 is a legal no-op.
REQ-025 PSLVERR=1 only in the completing cycle, for misaligned address, out-of-range index, or write to a read-only register; no register changes on error.
REQ-026 PRDATA SHALL show the addressed register in the completing cycle of a valid read, else 0 (including error reads and all writes).
REQ-027 Read-only register i SHALL load hw_wdata slice i when hw_we[i]=1; hw_we on read/write registers SHALL be ignored.
REQ-028 Read completing in the same cycle as a hw_we load of the same register SHALL return the pre-load value.
REQ-029 PREADY, PSLVERR and PRDATA SHALL be 0 outside the completing cycle.

Reset
REQ-030 PRESET=1 SHALL immediately force state IDLE, counter 0, all registers 0, PREADY=0, PSLVERR=0, PRDATA=0, regs_flat=0, regardless of PCLK.
REQ-031 Reset asserted mid-transfer SHALL abort it with no register update; first transfer after release SHALL behave as from IDLE.

Verification (DATA_WIDTH=32, NUM_REGS=16, WAIT_STATES=2, RO_MASK=16'h8000)
REQ-032 Write 0xDEADBEEF to 0x04, PSTRB=4'hF, then read 0x04 -> PREADY high exactly in 4th cycle of each transfer; PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-033 Write 0x11223344 to 0x08 PSTRB=4'hF, then 0xAABBCCDD PSTRB=4'b0101 -> read 0x08 returns 0x11BB33DD.
REQ-034 Write to 0x3C (reg 15, read-only) with hw_we[15]=0 -> PSLVERR=1 in completing cycle, reg 15 stays 0; pulse hw_we[15] with 0x0000CAFE -> read 0x3C returns 0x0000CAFE.
REQ-035 Read 0x40 (index 16) and read 0x05 (misaligned) -> PSLVERR=1, PRDATA=0 each; no register changed.
REQ-036 Deassert PSELx during 2nd ACCESS cycle of write 0x12345678 to 0x0C -> no PREADY, reg 3 unchanged; next transfer completes normally.
REQ-037 Assert PRESET during ACCESS of write to 0x10 after regs loaded -> all outputs and regs_flat 0 immediately; write not committed.
